// File: rtl/pll_reset_sequencer.sv
// Power-up and lock-loss reset sequencer for the iCE40 PLL, clocked by the 12 MHz reference.
// Optional lock watchdog (PLL retry on lock timeout) enabled by defining PLL_RST_WATCHDOG_EN.
module pll_reset_sequencer #(
   parameter int RESET_CYCLES  = 16,
   parameter int STABLE_CYCLES = 1024,
   parameter int LOCK_TIMEOUT  = 12000
) (
   input  logic       clock_in,
   input  logic       reset,
   input  logic       locked,
   output logic       pll_resetb,
   output logic       sys_reset,
   output logic       ready,
   output logic [7:0] lock_loss_count
);

   localparam int BASE_MAX = (RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES;
`ifdef PLL_RST_WATCHDOG_EN
   localparam int MAX_CYCLES = (BASE_MAX > LOCK_TIMEOUT) ? BASE_MAX : LOCK_TIMEOUT;
`else
   localparam int MAX_CYCLES = BASE_MAX;
`endif
   localparam int CW = $clog2(MAX_CYCLES) + 1;

   localparam logic [CW-1:0] RESET_LAST  = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
`ifdef PLL_RST_WATCHDOG_EN
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
`endif

   // Every cycle count must be at least one for the terminal-count compares to be reachable.
   if (RESET_CYCLES < 1 || STABLE_CYCLES < 1 || LOCK_TIMEOUT < 1) begin : g_param_check
      $error("pll_reset_sequencer: cycle parameters must be >= 1");
   end

   typedef enum logic [1:0] {
      PLL_RESET,
      WAIT_LOCK,
      STABLE,
      RUN
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic            lock_meta;
   logic            lock_s;
   logic            pll_resetb_next;
   logic            sys_reset_next;
   logic            ready_next;
   logic [7:0]      lock_loss_next;

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= locked;
         lock_s    <= lock_meta;
      end
   end

   // Outputs are registered alongside the state so they change on the same edge.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state           <= PLL_RESET;
         count           <= '0;
         pll_resetb      <= 1'b0;
         sys_reset       <= 1'b1;
         ready           <= 1'b0;
         lock_loss_count <= 8'd0;
      end else begin
         state           <= state_next;
         count           <= count_next;
         pll_resetb      <= pll_resetb_next;
         sys_reset       <= sys_reset_next;
         ready           <= ready_next;
         lock_loss_count <= lock_loss_next;
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      case (state)
         PLL_RESET: begin
            if (count == RESET_LAST) begin
               state_next = WAIT_LOCK;
               count_next = '0;
            end else begin
               count_next = count + CW'(1);
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_next = STABLE;
               count_next = '0;
            end
`ifdef PLL_RST_WATCHDOG_EN
            else if (count == TIMEOUT_LAST) begin
               state_next = PLL_RESET;
               count_next = '0;
            end else begin
               count_next = count + CW'(1);
            end
`endif
         end
         STABLE: begin
            if (!lock_s) begin
               state_next = WAIT_LOCK;
               count_next = '0;
            end else if (count == STABLE_LAST) begin
               state_next = RUN;
               count_next = '0;
            end else begin
               count_next = count + CW'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_next = WAIT_LOCK;
               count_next = '0;
            end
         end
         default: begin
            state_next = PLL_RESET;
            count_next = '0;
         end
      endcase
   end

   always_comb begin
      pll_resetb_next = (state_next != PLL_RESET);
      sys_reset_next  = (state_next != RUN);
      ready_next      = (state_next == RUN);
      lock_loss_next  = lock_loss_count;
      if (state == RUN && !lock_s && lock_loss_count != 8'hFF) begin
         lock_loss_next = lock_loss_count + 8'd1;
      end
   end

endmodule
